fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the async FIFO write port (wr_pointer + memory write side) between NUM_REQ requesters in the write clock domain.
- Grants one requester at a time for a burst. The burst ends on a packet-last beat, when MAX_BURST beats have been accepted, or when the requester abandons.
- Drives wr_en/wr_data into the FIFO write side and honours the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of requesters (power of 2, >=2)
- DATA_WIDTH, 8, FIFO data width
- MAX_BURST, 8, max beats accepted per grant (>=1)

Ports:
- w_clk  in  1  write-domain clock
- w_reset_n  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester data valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  last beat of packet, qualified by req_valid
- req_ready  out  NUM_REQ  per-requester beat accepted this cycle
- full  in  1  FIFO full from write pointer logic
- wr_en  out  1  FIFO write enable
- wr_data  out  DATA_WIDTH  FIFO write data
- wr_src  out  $clog2(NUM_REQ)  index of granted requester
- busy  out  1  state==BURST

Behaviour:
Reset (w_reset_n=0 at a w_clk edge):
- state=IDLE; grant=0; rr_ptr=0; beat_cnt=0.
- wr_en, req_ready, busy are 0; wr_src=0; wr_data=0.
- Reset mid-burst abandons the burst immediately; no further beats are accepted.

State machine (registered state, grant, rr_ptr, beat_cnt):
- IDLE:
  - If any req_valid: grant = first asserted index searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. Then beat_cnt=0 and state goes to BURST next cycle.
  - Else remain in IDLE.
  - There is no beat transfer in IDLE, so arbitration latency is 1 cycle.
- BURST, g = grant:
  - Outputs (combinational from registered state): req_ready[g] = !full; all other req_ready = 0; wr_en = req_valid[g] && !full; wr_data = req_data[g]; wr_src = g.
  - Beat accepted when wr_en=1: beat_cnt increments.
  - Release to IDLE at the clock edge when any of the following holds:
    - (a) an accepted beat has req_last[g]=1;
    - (b) an accepted beat makes beat_cnt reach MAX_BURST;
    - (c) req_valid[g]=0, regardless of full.
  - On release: rr_ptr = (g+1) mod NUM_REQ; beat_cnt=0.
  - full=1: stall. No accept, beat_cnt held, grant held, and req_valid[g] must stay asserted to keep the grant.
- Every release passes through IDLE, giving exactly one bubble cycle between bursts.
- wr_src and wr_data in IDLE hold the last grant and its data; wr_en is 0.
- wr_en must never be 1 while full=1; the FIFO receives no write while full.
- Requesters not granted see req_ready=0 and must hold their data.
- req_last on a beat that also hits MAX_BURST gives a single release (not double counted).
- rr_ptr wraps NUM_REQ-1 -> 0.
- beat_cnt width is $clog2(MAX_BURST+1).

Test Plan:
- Reset: hold w_reset_n=0 3 cycles with all req_valid=1 -> wr_en=0, req_ready=0000, busy=0, wr_src=0. First grant after release goes to requester 0.
- Single packet: req 1 sends 0xA1,0xA2,0xA3, last on 0xA3 -> 1 cycle after valid, busy=1 and wr_src=1. wr_en=1 for 3 cycles with data A1,A2,A3, then IDLE; rr_ptr=2.
- Fairness: all 4 valid continuously, no last -> grants 0,1,2,3,0. Each grant gives 8 wr_en pulses, with exactly one idle cycle between bursts.
- Backpressure: req 0 streaming, full=1 for 5 cycles after beat 3 -> wr_en=0 and req_ready[0]=0 during those 5 cycles. Beats resume at 4; burst still totals 8 beats.
- Abandon: req 2 granted, drops valid after 2 beats, req 0 valid -> release after beat 2 and rr_ptr=3. Next grant is req 0 via wrap search (3 not valid).
- Reset mid-burst: w_reset_n=0 during beat 4 of req 3 -> next cycle wr_en=0 and busy=0. After release with req 0 and req 3 valid, req 0 is granted.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the write-side requesters, the arbiter and the FIFO write port.
// The master modport is the arbiter; the slave modport is whatever drives requests and full.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          wr_en;
  logic [DATA_WIDTH-1:0]         wr_data;
  logic [IDX_W-1:0]              wr_src;
  logic                          busy;

  modport master (
    input  req_valid, req_data, req_last, full,
    output req_ready, wr_en, wr_data, wr_src, busy
  );

  modport slave (
    output req_valid, req_data, req_last, full,
    input  req_ready, wr_en, wr_data, wr_src, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ write-domain requesters.
// Each grant lasts until packet-last, MAX_BURST accepted beats, or the requester drops valid.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 8
) (
  input  logic                w_clk,
  input  logic                w_reset_n,
  fifo_wr_arbiter_if.master   bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rrPtr_q, rrPtr_d;
  logic [CNT_W-1:0]   beatCnt_q, beatCnt_d;
  logic               granted_q, granted_d;

  logic [IDX_W-1:0]   pickIdx;
  logic [IDX_W-1:0]   cand;
  logic               pickFound;
  logic [NUM_REQ-1:0] reqReady;
  logic               wrEn;
  logic [DATA_WIDTH-1:0] selData;

  // Power-of-two NUM_REQ lets the index adder wrap the search naturally.
  always_comb begin
    pickIdx   = rrPtr_q;
    pickFound = 1'b0;
    cand      = rrPtr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rrPtr_q + IDX_W'(k);
      if (!pickFound && bus.req_valid[cand]) begin
        pickIdx   = cand;
        pickFound = 1'b1;
      end
    end
  end

  always_comb begin
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) selData = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rrPtr_d   = rrPtr_q;
    beatCnt_d = beatCnt_q;
    granted_d = granted_q;
    reqReady  = '0;
    wrEn      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pickFound) begin
          grant_d   = pickIdx;
          granted_d = 1'b1;
          beatCnt_d = '0;
          state_d   = BURST;
        end
      end

      BURST: begin
        // Reset low gates the handshake so a burst is abandoned without one more write.
        reqReady[grant_q] = !bus.full && w_reset_n;
        wrEn              = bus.req_valid[grant_q] && !bus.full && w_reset_n;
        if (wrEn) beatCnt_d = beatCnt_q + CNT_W'(1);

        if (!bus.req_valid[grant_q] ||
            (wrEn && (bus.req_last[grant_q] ||
                      (beatCnt_q + CNT_W'(1) == CNT_W'(MAX_BURST))))) begin
          state_d   = IDLE;
          rrPtr_d   = grant_q + IDX_W'(1);
          beatCnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rrPtr_q   <= '0;
      beatCnt_q <= '0;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rrPtr_q   <= rrPtr_d;
      beatCnt_q <= beatCnt_d;
      granted_q <= granted_d;
    end
  end

  // wr_data reads zero until the first grant, then follows the current or last granted requester.
  assign bus.req_ready = reqReady;
  assign bus.wr_en     = wrEn;
  assign bus.wr_src    = grant_q;
  assign bus.wr_data   = granted_q ? selData : '0;
  assign bus.busy      = (state_q == BURST);
endmodule
